// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the shared
// memory port. slave = arbiter view, master = environment view.
interface cpu_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Fetch/data arbiter onto a single-outstanding memory port (IDLE/CMD/WAIT).
// Define CPU_MEM_ARB_RR_EN for round-robin on contention; default data wins.
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic               clock,
    input logic               reset,
    cpu_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

    state_t                r_state;
    logic                  r_owner_d;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_if_rvalid;
    logic                  r_d_rvalid;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic w_idle;
    logic w_pick_d;
    logic w_gnt_d;
    logic w_gnt_i;

    assign w_idle = (r_state == IDLE) && !reset;

`ifdef CPU_MEM_ARB_RR_EN
    // 1 = data port owned the last grant; reset value means fetch.
    logic r_last_d;

    assign w_pick_d = bus.d_req && (!bus.if_req || !r_last_d);

    always_ff @(posedge clock) begin
        if (reset)
            r_last_d <= 1'b0;
        else if (w_gnt_d || w_gnt_i)
            r_last_d <= w_gnt_d;
    end
`else
    assign w_pick_d = bus.d_req;
`endif

    assign w_gnt_d = w_idle && w_pick_d;
    assign w_gnt_i = w_idle && bus.if_req && !w_pick_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner_d   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_gnt_d || w_gnt_i) begin
                        r_owner_d   <= w_gnt_d;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_gnt_d && bus.d_we;
                        r_mem_addr  <= w_gnt_d ? bus.d_addr : bus.if_addr;
                        r_mem_wdata <= w_gnt_d ? bus.d_wdata : '0;
                        r_state     <= CMD;
                    end
                end
                CMD: begin
                    if (bus.mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        if (r_owner_d) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= bus.mem_rdata;
                        end else begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= bus.mem_rdata;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.if_gnt    = w_gnt_i;
    assign bus.d_gnt     = w_gnt_d;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: fetch, store backpressure, contention,
// reset mid-transaction and spurious memory strobes.
module tb_cpu_mem_arbiter;
    logic clock;
    logic reset;

    cpu_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    cpu_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_chk;
    int n_err;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called in the first CMD cycle; returns in the cycle the rvalid pulse is up.
    task automatic mem_serve(input int rdy_wait, input int lat,
                             input logic [31:0] data);
        bus.mem_ready = 1'b0;
        repeat (rdy_wait) tick();
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        repeat (lat) tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic exp_d;
    logic prev_d;

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        bus.if_req = 1'b0;     bus.if_addr = '0;
        bus.d_req = 1'b0;      bus.d_we = 1'b0;
        bus.d_addr = '0;       bus.d_wdata = '0;
        bus.mem_ready = 1'b0;  bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;

        do_reset();
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_rvalids", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
        check("rst_gnts", 32'({bus.if_gnt, bus.d_gnt}), 32'd0);

        // Single fetch
        bus.if_req = 1'b1;
        bus.if_addr = 32'h100;
        #1;
        check("f_if_gnt", 32'(bus.if_gnt), 32'd1);
        check("f_d_gnt", 32'(bus.d_gnt), 32'd0);
        tick();
        bus.if_req = 1'b0;
        check("f_mem_req", 32'(bus.mem_req), 32'd1);
        check("f_mem_addr", bus.mem_addr, 32'h100);
        check("f_mem_we", 32'(bus.mem_we), 32'd0);
        check("f_gnt_cmd", 32'(bus.if_gnt), 32'd0);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("f_mem_req_wait", 32'(bus.mem_req), 32'd0);
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        #1;
        check("f_rv_early", 32'(bus.if_rvalid), 32'd0);
        tick();
        bus.mem_rvalid = 1'b0;
        check("f_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("f_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        check("f_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        tick();
        check("f_rv_pulse", 32'(bus.if_rvalid), 32'd0);
        check("f_rdata_hold", bus.if_rdata, 32'hDEADBEEF);

        // Store with three cycles of backpressure
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h40;
        bus.d_wdata = 32'h12345678;
        #1;
        check("s_d_gnt", 32'(bus.d_gnt), 32'd1);
        tick();
        bus.d_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3);
            #1;
            check("s_mem_req", 32'(bus.mem_req), 32'd1);
            check("s_mem_we", 32'(bus.mem_we), 32'd1);
            check("s_mem_addr", bus.mem_addr, 32'h40);
            check("s_mem_wdata", bus.mem_wdata, 32'h12345678);
            tick();
        end
        bus.mem_ready = 1'b0;
        check("s_mem_req_off", 32'(bus.mem_req), 32'd0);
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        check("s_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        check("s_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        tick();
        check("s_rv_pulse", 32'(bus.d_rvalid), 32'd0);

        // Contention from a fresh reset (last owner = fetch)
        do_reset();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h200;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h300;
        prev_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef CPU_MEM_ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            #1;
            check("c_d_gnt", 32'(bus.d_gnt), 32'(exp_d));
            check("c_if_gnt", 32'(bus.if_gnt), 32'(!exp_d));
            if (k > 0) begin
                check("c_d_rvalid", 32'(bus.d_rvalid), 32'(prev_d));
                check("c_if_rvalid", 32'(bus.if_rvalid), 32'(!prev_d));
            end
            tick();
            check("c_mem_addr", bus.mem_addr, exp_d ? 32'h300 : 32'h200);
            mem_serve(0, 1, 32'hC000 + 32'(k));
            prev_d = exp_d;
        end
        bus.d_req = 1'b0;
        #1;
        check("c_last_if_gnt", 32'(bus.if_gnt), 32'd1);
        check("c_last_d_gnt", 32'(bus.d_gnt), 32'd0);
        tick();
        bus.if_req = 1'b0;
        mem_serve(1, 0, 32'hF00D);
        check("c_last_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("c_last_rdata", bus.if_rdata, 32'hF00D);
        tick();

        // Reset while waiting for the load response
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h80;
        tick();
        bus.d_req = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'hAAAA5555;
        #1;
        check("r_mem_req", 32'(bus.mem_req), 32'd0);
        check("r_mem_addr", bus.mem_addr, 32'd0);
        check("r_if_rdata", bus.if_rdata, 32'd0);
        tick();
        bus.mem_rvalid = 1'b0;
        check("r_no_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
        check("r_d_rdata", bus.d_rdata, 32'd0);
        check("r_mem_req2", 32'(bus.mem_req), 32'd0);

        // Spurious response in IDLE with no requests
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h5A5A5A5A;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_ready = 1'b0;
        check("i_no_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
        check("i_mem_req", 32'(bus.mem_req), 32'd0);
        check("i_if_rdata", bus.if_rdata, 32'd0);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h444;
        #1;
        check("i_if_gnt", 32'(bus.if_gnt), 32'd1);
        tick();
        bus.if_req = 1'b0;
        check("i_mem_addr", bus.mem_addr, 32'h444);
        mem_serve(0, 0, 32'h13579BDF);
        check("i_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("i_if_rdata2", bus.if_rdata, 32'h13579BDF);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu_mem_arbiter.md
CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, width of all data ports.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 if_req / if_addr  input  1 / ADDR_WIDTH  fetch read request and address, held until granted.
REQ-006 if_gnt / if_rvalid / if_rdata  output  1 / 1 / DATA_WIDTH  fetch grant pulse, read-data pulse, read data.
REQ-007 d_req / d_we / d_addr / d_wdata  input  1 / 1 / ADDR_WIDTH / DATA_WIDTH  execute-stage load/store request, held until granted.
REQ-008 d_gnt / d_rvalid / d_rdata  output  1 / 1 / DATA_WIDTH  data grant pulse, completion pulse (loads and stores), read data.
REQ-009 mem_req / mem_we / mem_addr / mem_wdata  output  1 / 1 / ADDR_WIDTH / DATA_WIDTH  shared memory port command.
REQ-010 mem_ready / mem_rvalid / mem_rdata  input  1 / 1 / DATA_WIDTH  command accept, response strobe, response data.

Function
REQ-011 FSM states IDLE, CMD, WAIT; exactly one transaction outstanding on the memory port.
REQ-012 In IDLE with any request pending, the arbiter SHALL assert exactly one of if_gnt/d_gnt combinationally in that cycle and move to CMD.
REQ-013 Default policy: d_req wins over if_req when both are asserted in the same cycle.
REQ-014 On grant, owner, address, we (forced 0 for fetch) and wdata SHALL be registered; mem_* outputs driven only from these registers.
REQ-015 In CMD, mem_req SHALL be 1 with stable mem_we/mem_addr/mem_wdata until the cycle mem_ready=1; then move to WAIT.
REQ-016 In WAIT, mem_req=0; the first mem_rvalid=1 SHALL, on the next edge, pulse owner's rvalid for exactly one cycle with rdata = captured mem_rdata, and return to IDLE.
REQ-017 A new grant is allowed in the same cycle the previous rvalid pulse is asserted (back-to-back throughput: grant, 1 CMD cycle minimum, memory latency, 1 return cycle).
REQ-018 mem_rvalid outside WAIT SHALL be ignored; mem_ready outside CMD SHALL be ignored.
REQ-019 No grant pulse in CMD or WAIT; requests arriving then wait until IDLE.
REQ-020 Stores SHALL complete via d_rvalid; d_rdata on store completion is don't-care.
REQ-021 if_rdata/d_rdata SHALL hold last delivered value between pulses.

Reset
REQ-022 Reset SHALL force IDLE and all outputs to 0 (grants, rvalids, mem_req, mem_we, mem_addr, mem_wdata, rdata) on the next edge.
REQ-023 Reset mid-transaction SHALL abandon the transaction with no rvalid pulse; a late mem_rvalid after reset is ignored per REQ-018.
REQ-024 A 1-bit last-owner flag SHALL reset to "fetch", so after reset data wins the first contention under either policy.

Configuration
REQ-025 Macro CPU_MEM_ARB_RR_EN defined: on simultaneous requests, grant goes to the requester not granted last (round-robin via last-owner flag).
REQ-026 Macro CPU_MEM_ARB_RR_EN undefined: fixed data-over-fetch priority per REQ-013; last-owner flag unused.

Verification
REQ-027 Single fetch: if_req=1, if_addr=0x100, mem_ready=1 in first CMD cycle, mem_rvalid 2 cycles later with 0xDEADBEEF -> if_gnt one cycle, mem_addr=0x100 mem_we=0, if_rvalid one cycle after mem_rvalid with if_rdata=0xDEADBEEF.
REQ-028 Store backpressure: d_req=1 d_we=1 d_addr=0x40 d_wdata=0x12345678, mem_ready low 3 cycles -> mem_req high 4 cycles with stable values, d_rvalid one cycle after mem_rvalid.
REQ-029 Contention, macro undefined: if_req and d_req held high for 4 transactions -> all 4 grants to data; fetch granted only after d_req drops.
REQ-030 Contention, CPU_MEM_ARB_RR_EN defined: both held high for 4 transactions -> grant order D, I, D, I.
REQ-031 Reset in WAIT then mem_rvalid=1 the following cycle -> no if_rvalid/d_rvalid pulse, state IDLE, all outputs 0.
REQ-032 Spurious mem_rvalid=1 in IDLE with no requests -> no rvalid pulse, no state change.
